// File: rtl/midi_irq_arbiter_pkg.sv
// Shared types and constants for the MIDI cartridge interrupt arbiter.
// Source indices double as the fixed priority order (higher index wins).
package midi_irq_arbiter_pkg;

  localparam int NUM_SRC = 4;

  localparam int SRC_RX  = 0;
  localparam int SRC_TX  = 1;
  localparam int SRC_ERR = 2;
  localparam int SRC_TMR = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  // One-hot of the highest-priority set bit, or zero when nothing is set.
  function automatic logic [NUM_SRC-1:0] prio_onehot(input logic [NUM_SRC-1:0] v);
    logic [NUM_SRC-1:0] r;
    r = '0;
    if (v[SRC_TMR])      r[SRC_TMR] = 1'b1;
    else if (v[SRC_ERR]) r[SRC_ERR] = 1'b1;
    else if (v[SRC_TX])  r[SRC_TX]  = 1'b1;
    else if (v[SRC_RX])  r[SRC_RX]  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/midi_irq_arbiter_sync.sv
// Multi-flop synchronizer for one asynchronous event line, followed by a
// registered rising-edge detector producing a single-cycle pulse.
module midi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/midi_irq_arbiter.sv
// Latches MIDI cartridge events as pending flags and presents one masked,
// fixed-priority source at a time to the CPU until it is acknowledged.
module midi_irq_arbiter
  import midi_irq_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] mask,
  input  logic [NUM_SRC-1:0] clr_pend,
  input  logic               ack,
  output logic [NUM_SRC-1:0] grant,
  output logic               irq_n,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  logic [NUM_SRC-1:0] rise;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sync
      midi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (req[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] grant_reg, grant_next;
  logic               irq_n_reg, irq_n_next;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      grant_reg   <= '0;
      irq_n_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      grant_reg   <= grant_next;
      irq_n_reg   <= irq_n_next;
    end
  end

  always_comb begin
    eligible = pending_reg & mask;
    ack_clr  = (state_reg == ASSERT && ack) ? grant_reg : '0;
    // New edges are OR-ed in last so a coincident clear never loses an event.
    pending_next = (pending_reg & ~clr_pend & ~ack_clr) | rise;

    state_next = state_reg;
    grant_next = grant_reg;
    irq_n_next = irq_n_reg;

    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          grant_next = prio_onehot(eligible);
          irq_n_next = 1'b0;
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        // Ack, mask drop and software clear all release the grant the same way.
        if (ack || ((grant_reg & mask) == '0) || ((grant_reg & pending_next) == '0)) begin
          grant_next = '0;
          irq_n_next = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        grant_next = '0;
        irq_n_next = 1'b1;
        state_next = IDLE;
      end
      default: begin
        grant_next = '0;
        irq_n_next = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign grant   = grant_reg;
  assign irq_n   = irq_n_reg;
  assign pending = pending_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_midi_irq_arbiter.sv
// Directed and randomized bench for midi_irq_arbiter against a source-index
// reference model driven by the sampled req history.
module tb_midi_irq_arbiter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req, mask, clr_pend;
  logic       ack;
  logic [3:0] grant, pending;
  logic       irq_n, busy;

  int errors = 0;
  int checks = 0;

  // Model: req samples (newest first), pending set, granted index (-1 none), gap flag.
  logic [3:0] hist[$];
  logic [3:0] m_pend;
  int         m_gnt;
  bit         m_gap;

  midi_irq_arbiter #(.SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .mask    (mask),
    .clr_pend(clr_pend),
    .ack     (ack),
    .grant   (grant),
    .irq_n   (irq_n),
    .pending (pending),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (S + 3) hist.push_back(4'b0000);
    m_pend = 4'b0000;
    m_gnt  = -1;
    m_gap  = 1'b0;
  endtask

  // An event is a req bit seen high S+1 samples ago that was low the sample before.
  task automatic model_edge();
    logic [3:0] set_v, elig, pend_n, ack_bit;
    hist.push_front(req);
    void'(hist.pop_back());
    set_v   = hist[S+1] & ~hist[S+2];
    ack_bit = (m_gnt >= 0 && ack) ? (4'b0001 << m_gnt) : 4'b0000;
    pend_n  = (m_pend & ~clr_pend & ~ack_bit) | set_v;
    if (m_gnt >= 0) begin
      if (ack || !mask[m_gnt] || !pend_n[m_gnt]) begin
        m_gnt = -1;
        m_gap = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      elig = m_pend & mask;
      for (int i = 3; i >= 0; i--) begin
        if (elig[i] && m_gnt < 0) m_gnt = i;
      end
    end
    m_pend = pend_n;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_gnt >= 0) ? (4'b0001 << m_gnt) : 4'b0000;
    chk({tag, ".grant"}, grant, eg);
    chk({tag, ".irq_n"}, {3'b000, irq_n}, {3'b000, (m_gnt < 0)});
    chk({tag, ".pending"}, pending, m_pend);
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, (m_gnt >= 0) || m_gap});
    chk({tag, ".onehot0"}, {3'b000, $onehot0(grant)}, 4'b0001);
    chk({tag, ".irq_vs_grant"}, {3'b000, (grant != 4'b0000)}, {3'b000, !irq_n});
  endtask

  task automatic step(input string tag, input int n = 1);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
      check_model(tag);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    req      = 4'b0000;
    mask     = 4'b0000;
    clr_pend = 4'b0000;
    ack      = 1'b0;
    model_reset();
    #12;
    chk("rst.grant", grant, 4'b0000);
    chk("rst.irq_n", {3'b000, irq_n}, 4'b0001);
    chk("rst.pending", pending, 4'b0000);
    chk("rst.busy", {3'b000, busy}, 4'b0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Single source: edge to pending in S+1 edges, IRQ one edge later.
    mask = 4'hF;
    req  = 4'b0100;
    step("t1.cap");
    step("t1.sync", 2);
    chk("t1.pend_early", pending, 4'b0000);
    step("t1.pend");
    chk("t1.pend_set", pending, 4'b0100);
    chk("t1.irq_still_hi", {3'b000, irq_n}, 4'b0001);
    step("t1.assert");
    chk("t1.grant", grant, 4'b0100);
    chk("t1.irq_lo", {3'b000, irq_n}, 4'b0000);
    ack = 1'b1;
    step("t1.ack");
    ack = 1'b0;
    chk("t1.ack_grant", grant, 4'b0000);
    chk("t1.ack_irq", {3'b000, irq_n}, 4'b0001);
    chk("t1.ack_pend", pending, 4'b0000);
    req = 4'b0000;
    step("t1.idle", 3);

    // Two simultaneous sources: priority then back-to-back spacing.
    req = 4'b1001;
    step("t2.sync", 5);
    chk("t2.grant_hi", grant, 4'b1000);
    ack = 1'b1;
    step("t2.ack1");
    ack = 1'b0;
    chk("t2.gap", grant, 4'b0000);
    step("t2.idle");
    chk("t2.idle_grant", grant, 4'b0000);
    step("t2.regrant");
    chk("t2.grant_lo", grant, 4'b0001);
    ack = 1'b1;
    step("t2.ack2");
    ack = 1'b0;
    chk("t2.all_clear", pending, 4'b0000);
    req = 4'b0000;
    step("t2.idle", 3);

    // Masked event waits, then is withdrawn by a mask drop.
    mask = 4'b0111;
    req  = 4'b1000;
    step("t3.sync", 5);
    chk("t3.pend", pending, 4'b1000);
    chk("t3.irq_hi", {3'b000, irq_n}, 4'b0001);
    mask = 4'hF;
    step("t3.unmask");
    chk("t3.grant", grant, 4'b1000);
    mask = 4'b0111;
    step("t3.withdraw");
    chk("t3.wd_grant", grant, 4'b0000);
    chk("t3.wd_pend", pending, 4'b1000);
    chk("t3.wd_busy", {3'b000, busy}, 4'b0001);
    step("t3.gap_end");
    chk("t3.idle_busy", {3'b000, busy}, 4'b0000);
    clr_pend = 4'b1000;
    req      = 4'b0000;
    step("t3.clr");
    clr_pend = 4'b0000;

    // Set beats a simultaneous software clear; ack while idle is ignored.
    mask = 4'b0000;
    req  = 4'b0010;
    step("t4.first", 4);
    chk("t4.pend1", pending, 4'b0010);
    req = 4'b0000;
    step("t4.low");
    req = 4'b0010;
    step("t4.cap2", 3);
    clr_pend = 4'b0010;
    step("t4.coincide");
    clr_pend = 4'b0000;
    chk("t4.set_wins", pending, 4'b0010);
    ack = 1'b1;
    step("t4.idle_ack");
    ack = 1'b0;
    chk("t4.idle_ack_pend", pending, 4'b0010);
    chk("t4.idle_ack_busy", {3'b000, busy}, 4'b0000);

    // Asynchronous reset in the middle of a grant.
    mask = 4'hF;
    step("t5.assert");
    chk("t5.grant", grant, 4'b0010);
    reset_n = 1'b0;
    #2;
    chk("t5.rst_grant", grant, 4'b0000);
    chk("t5.rst_irq", {3'b000, irq_n}, 4'b0001);
    chk("t5.rst_pend", pending, 4'b0000);
    chk("t5.rst_busy", {3'b000, busy}, 4'b0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req     = 4'b0000;
    model_reset();
    step("t5.recover", 2);

    // Random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      req      = 4'($urandom);
      mask     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : mask | 4'($urandom);
      ack      = ($urandom_range(0, 3) == 0);
      clr_pend = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_irq_arbiter.md
Name: midi_irq_arbiter

Overview:
- Collects four asynchronous MIDI-cartridge event lines (UART RX ready, TX empty, framing/overrun error, timer tick).
- Latches each event as a pending flag and applies a CPU mask.
- Presents exactly one source at a time as a one-hot grant vector; that vector drives the downstream 4-to-2 encoder's x0..x3 inputs, which produce the interrupt source code the VIC-20 reads.
- Drives the active-low IRQ line and holds the grant stable until the CPU acknowledges.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per request input (legal 2..4)
NUM_SRC, 4, number of sources; fixed at 4 to match the downstream encoder (not to be overridden)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req  input  4  raw event lines, asynchronous to clk; bit 3 = highest priority
mask  input  4  1 = source enabled for arbitration; from CPU register, clk-synchronous
clr_pend  input  4  one-cycle pulse; clears the matching pending bits (CPU software clear)
ack  input  1  one-cycle pulse; CPU acknowledges the currently granted source
grant  output  4  one-hot granted source, or all-zero; feeds encoder x0..x3
irq_n  output  1  interrupt request to CPU, active low, registered
pending  output  4  raw pending flags, for CPU status read
busy  output  1  high when state is not IDLE

Behaviour:
- Reset values (asynchronous, whole block):
  - synchronizer flops, edge-history flops and pending = 0
  - grant = 4'b0000, irq_n = 1, busy = 0, state = IDLE
- Reset asserted mid-operation aborts any grant immediately. No event is remembered across reset.
- Synchronizer: each req bit passes through SYNC_STAGES flops. Rising-edge detect is sync_out & ~prev. Level-high input without a new edge sets nothing further.
- Pending:
  - A rising edge sets pending[i] regardless of mask.
  - clr_pend[i] clears pending[i].
  - An ack in ASSERT clears pending[granted].
  - If set and clear hit the same bit in the same cycle, set wins (the event is not lost).
  - Latency: a req edge appears in pending SYNC_STAGES+1 clk cycles after the first capturing edge.
- Eligible = pending & mask. Fixed priority: bit 3 > 2 > 1 > 0.
- State machine (IDLE, ASSERT, GAP):
  - IDLE, when eligible != 0: register grant = one-hot of the highest eligible bit; next state ASSERT; irq_n goes low on the same edge. Latency from pending set to irq_n low is 1 cycle.
  - ASSERT: grant and irq_n are held constant. Higher-priority arrivals do not pre-empt.
    - On ack: clear pending[granted]; grant <= 0, irq_n <= 1; next state GAP.
    - If mask for the granted bit drops (without ack): withdraw; grant <= 0, irq_n <= 1, pending untouched; next state GAP.
    - If pending for the granted bit is cleared via clr_pend: same withdraw action as a mask drop.
    - If ack and withdrawal coincide, ack takes precedence.
  - GAP: one cycle with irq_n high and grant = 0, guaranteeing a visible IRQ deassertion edge. Next state is always IDLE.
  - ack outside ASSERT is ignored.
- Invariant: grant is always zero or exactly one bit set. grant != 0 if and only if irq_n == 0 if and only if state == ASSERT.
- busy = (state != IDLE).
- Back-to-back: with two sources pending, the second grant issues 3 cycles after ack (GAP, then IDLE decision, then ASSERT).

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, ASSERT=2'd1, GAP=2'd2
  - NUM_SRC=4
  - source index constants: SRC_RX=0, SRC_TX=1, SRC_ERR=2, SRC_TMR=3
- One sub-module, midi_sync_edge: a parameterized SYNC_STAGES synchronizer with rising-edge pulse output, instanced per source.
- Priority selection and FSM stay in the top module.

Test Plan:
- Reset, then req=4'b0100 with mask=4'hF: pending[2] rises 3 cycles after the capturing edge (SYNC_STAGES=2); irq_n low 1 cycle later; grant=4'b0100; ack then gives irq_n=1, grant=0, pending=0.
- req rising on bits 0 and 3 in the same cycle: grant=4'b1000 first; after ack, grant=4'b0001 exactly 3 cycles later; a second ack clears all.
- mask=4'b0111 with a req[3] edge: pending=4'b1000, irq_n stays 1. Later mask=4'hF: grant=4'b1000 on the next cycle. Then drop mask[3] while in ASSERT: withdrawal, pending[3] still 1, one GAP cycle.
- A new req[1] edge lands in the same cycle as clr_pend=4'b0010: pending[1]=1 (set wins). An ack while IDLE has no effect.
- Assert reset_n low while in ASSERT with grant=4'b0010: asynchronously grant=0, irq_n=1, pending=0, busy=0 without waiting for clk.
- Random req/mask/ack/clr_pend over 10k cycles: assertion checks $onehot0(grant) and (grant!=0)==(irq_n==0) on every cycle.
